nic_cpu_responder: RTL and testbench

// - Network-interface end of the processor NIC port: the responder to the CPU's nicEn/nicWrEn/nic_addr load/store accesses.
// - Holds one 64-bit input-channel buffer (router -> CPU) and one 64-bit output-channel buffer (CPU -> router).
// - Each buffer has a 1-bit status flag that the CPU polls through the same 2-bit address space.
// - Sits between the CPU's EX_MEM stage and the local router port.
// - Talks to the router with a send/ready handshake on each direction.
//

---
 rtl/nic_cpu_responder.sv | 134 +++++++++++++
 tb/tb_nic_cpu_responder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/nic_cpu_responder.sv
// nic_cpu_responder
// Network-interface end of the processor NIC port. It answers the CPU's
// nicEn/nicWrEn/addr load/store accesses. It holds one inbound buffer
// (router -> CPU) and one outbound buffer (CPU -> router). Each buffer has a
// full flag that the CPU polls.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   addr     CPU register select (bit [0] is MSB)
//            00 = input buffer, 01 = input status, 10 = output buffer, 11 = output status
//   d_in     CPU store data
//   d_out    CPU load data (combinational, zero when not reading)
//   nicEn    CPU access strobe
//   nicWrEn  1 = store, 0 = load
//   net_si   router offers a packet on net_di
//   net_ri   NIC can accept a packet (input buffer empty)
//   net_di   packet data from the router
//   net_so   NIC offers a packet on net_do (output buffer full)
//   net_ro   router can accept the packet on net_do
//   net_do   packet data to the router
//
// Data buses are numbered [0:DATA_WIDTH-1], so bit [DATA_WIDTH-1] is the LSB.
// A status read therefore returns the numeric value 0 or 1.
module nic_cpu_responder #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [0:ADDR_WIDTH-1]   addr,
    input  logic [0:DATA_WIDTH-1]   d_in,
    output logic [0:DATA_WIDTH-1]   d_out,
    input  logic                    nicEn,
    input  logic                    nicWrEn,
    input  logic                    net_si,
    output logic                    net_ri,
    input  logic [0:DATA_WIDTH-1]   net_di,
    output logic                    net_so,
    input  logic                    net_ro,
    output logic [0:DATA_WIDTH-1]   net_do
);

    localparam logic [0:ADDR_WIDTH-1] ADDR_IN_BUF   = 2'b00;
    localparam logic [0:ADDR_WIDTH-1] ADDR_IN_STAT  = 2'b01;
    localparam logic [0:ADDR_WIDTH-1] ADDR_OUT_BUF  = 2'b10;
    localparam logic [0:ADDR_WIDTH-1] ADDR_OUT_STAT = 2'b11;

    logic [0:DATA_WIDTH-1] in_buf_q,  in_buf_d;
    logic                  in_full_q, in_full_d;
    logic [0:DATA_WIDTH-1] out_buf_q, out_buf_d;
    logic                  out_full_q, out_full_d;

    logic rd_s;
    logic wr_s;

    // Decode the CPU access strobe into a load and a store qualifier
    always_comb begin
        rd_s = nicEn & ~nicWrEn;
        wr_s = nicEn &  nicWrEn;
    end

    // Input channel next state.
    // Accepting a router packet and a destructive CPU read are exclusive:
    // acceptance needs in_full=0, and the read only clears when in_full=1.
    always_comb begin
        in_buf_d  = in_buf_q;
        in_full_d = in_full_q;
        if (net_si && !in_full_q) begin
            in_buf_d  = net_di;
            in_full_d = 1'b1;
        end else if (rd_s && (addr == ADDR_IN_BUF) && in_full_q) begin
            in_full_d = 1'b0;
        end else begin
            in_full_d = in_full_q;
        end
    end

    // Output channel next state.
    // A store is judged on the pre-edge flag, so a store in the cycle the
    // router drains the buffer is dropped.
    always_comb begin
        out_buf_d  = out_buf_q;
        out_full_d = out_full_q;
        if (wr_s && (addr == ADDR_OUT_BUF) && !out_full_q) begin
            out_buf_d  = d_in;
            out_full_d = 1'b1;
        end else if (out_full_q && net_ro) begin
            out_full_d = 1'b0;   // out_buf keeps its value after the drain
        end else begin
            out_full_d = out_full_q;
        end
    end

    // Buffer and flag registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_buf_q   <= {DATA_WIDTH{1'b0}};
            in_full_q  <= 1'b0;
            out_buf_q  <= {DATA_WIDTH{1'b0}};
            out_full_q <= 1'b0;
        end else begin
            in_buf_q   <= in_buf_d;
            in_full_q  <= in_full_d;
            out_buf_q  <= out_buf_d;
            out_full_q <= out_full_d;
        end
    end

    // CPU load data. This is combinational because the CPU samples it in the
    // cycle of the access.
    always_comb begin
        d_out = {DATA_WIDTH{1'b0}};
        if (rd_s) begin
            case (addr)
                ADDR_IN_BUF:   d_out = in_buf_q;
                ADDR_IN_STAT:  d_out = {{(DATA_WIDTH-1){1'b0}}, in_full_q};
                ADDR_OUT_BUF:  d_out = {DATA_WIDTH{1'b0}};
                ADDR_OUT_STAT: d_out = {{(DATA_WIDTH-1){1'b0}}, out_full_q};
                default:       d_out = {DATA_WIDTH{1'b0}};
            endcase
        end else begin
            d_out = {DATA_WIDTH{1'b0}};
        end
    end

    // Router handshake outputs come straight from the registers
    always_comb begin
        net_ri = ~in_full_q;
        net_so = out_full_q;
        net_do = out_buf_q;
    end

endmodule

// File: tb/tb_nic_cpu_responder.sv
// Testbench for nic_cpu_responder. It runs directed scenarios and then
// randomized traffic. All results are checked against a behavioural model of
// the two one-entry mailboxes.
module tb_nic_cpu_responder;

    logic         clk;
    logic         reset;
    logic [0:1]   addr;
    logic [0:63]  d_in;
    logic [0:63]  d_out;
    logic         nicEn;
    logic         nicWrEn;
    logic         net_si;
    logic         net_ri;
    logic [0:63]  net_di;
    logic         net_so;
    logic         net_ro;
    logic [0:63]  net_do;

    int vec_cnt_r  = 0;
    int miss_cnt_r = 0;

    // Reference model: each channel is a mailbox that is either empty or holds a word
    logic [63:0] m_in_word;
    bit          m_in_full;
    logic [63:0] m_out_word;
    bit          m_out_full;

    nic_cpu_responder dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .d_in    (d_in),
        .d_out   (d_out),
        .nicEn   (nicEn),
        .nicWrEn (nicWrEn),
        .net_si  (net_si),
        .net_ri  (net_ri),
        .net_di  (net_di),
        .net_so  (net_so),
        .net_ro  (net_ro),
        .net_do  (net_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vec_cnt_r++;
        if (obs !== exp_v) begin
            miss_cnt_r++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [63:0] model_read(input logic [1:0] a);
        case (a)
            2'b00:   return m_in_word;
            2'b01:   return {63'd0, m_in_full};
            2'b11:   return {63'd0, m_out_full};
            default: return 64'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_in_word  = 64'd0;
        m_in_full  = 1'b0;
        m_out_word = 64'd0;
        m_out_full = 1'b0;
    endtask

    // Apply one cycle of stimulus, check the outputs mid-cycle, then advance the model at the edge
    task automatic cycle(input bit en, input bit we, input logic [1:0] a, input logic [63:0] din,
                         input bit si, input logic [63:0] di, input bit ro);
        bit cpu_rd_in;
        bit cpu_wr_out;
        @(negedge clk);
        nicEn = en; nicWrEn = we; addr = a; d_in = din;
        net_si = si; net_di = di; net_ro = ro;
        #1;
        chk_val("d_out",  d_out, (en && !we) ? model_read(a) : 64'd0);
        chk_val("net_ri", {63'd0, net_ri}, {63'd0, !m_in_full});
        chk_val("net_so", {63'd0, net_so}, {63'd0, m_out_full});
        chk_val("net_do", net_do, m_out_word);
        @(posedge clk);
        cpu_rd_in  = en && !we && (a == 2'b00);
        cpu_wr_out = en && we && (a == 2'b10);
        if (si && !m_in_full) begin
            m_in_word = di;
            m_in_full = 1'b1;
        end else if (cpu_rd_in && m_in_full) begin
            m_in_full = 1'b0;
        end
        if (cpu_wr_out && !m_out_full) begin
            m_out_word = din;
            m_out_full = 1'b1;
        end else if (m_out_full && ro) begin
            m_out_full = 1'b0;
        end
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 2'b00, 64'd0, 1'b0, 64'd0, 1'b0);
    endtask

    // Pull reset low in the middle of a cycle and check the outputs at once
    task automatic mid_reset();
        @(negedge clk);
        nicEn = 1'b1; nicWrEn = 1'b0; addr = 2'b01;
        net_si = 1'b0; net_ro = 1'b0;
        #2 reset = 1'b0;
        model_reset();
        #1;
        chk_val("rst_net_ri", {63'd0, net_ri}, 64'd1);
        chk_val("rst_net_so", {63'd0, net_so}, 64'd0);
        chk_val("rst_net_do", net_do, 64'd0);
        chk_val("rst_in_stat", d_out, 64'd0);
        addr = 2'b11;
        #1;
        chk_val("rst_out_stat", d_out, 64'd0);
        nicEn = 1'b0;
        #1;
        chk_val("rst_d_out", d_out, 64'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; nicEn = 1'b0; nicWrEn = 1'b0; addr = 2'b00;
        d_in = 64'd0; net_si = 1'b0; net_di = 64'd0; net_ro = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // T1: reset with the NIC idle
        idle();
        mid_reset();
        idle();

        // T2: inbound path
        cycle(1'b0, 1'b0, 2'b00, 64'd0, 1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0);
        cycle(1'b1, 1'b0, 2'b01, 64'd0, 1'b0, 64'd0, 1'b0);
        chk_val("t2_ri_low", {63'd0, net_ri}, 64'd0);
        cycle(1'b1, 1'b0, 2'b00, 64'd0, 1'b0, 64'd0, 1'b0);
        #1 chk_val("t2_ri_high", {63'd0, net_ri}, 64'd1);
        cycle(1'b1, 1'b0, 2'b01, 64'd0, 1'b0, 64'd0, 1'b0);
        // A read of an empty input buffer returns the stale word
        cycle(1'b1, 1'b0, 2'b00, 64'd0, 1'b0, 64'd0, 1'b0);

        // T3: outbound path
        cycle(1'b1, 1'b1, 2'b10, 64'h0123_4567_89AB_CDEF, 1'b0, 64'd0, 1'b0);
        #1 chk_val("t3_do", net_do, 64'h0123_4567_89AB_CDEF);
        cycle(1'b1, 1'b0, 2'b11, 64'd0, 1'b0, 64'd0, 1'b0);
        cycle(1'b1, 1'b0, 2'b10, 64'd0, 1'b0, 64'd0, 1'b0);
        cycle(1'b0, 1'b0, 2'b00, 64'd0, 1'b0, 64'd0, 1'b1);
        #1 chk_val("t3_so_low", {63'd0, net_so}, 64'd0);
        cycle(1'b1, 1'b0, 2'b11, 64'd0, 1'b0, 64'd0, 1'b0);

        // T4: overwrite protection, including a store in the drain cycle
        cycle(1'b1, 1'b1, 2'b10, 64'h1111_2222_3333_4444, 1'b0, 64'd0, 1'b0);
        cycle(1'b1, 1'b1, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd0, 1'b0);
        #1 chk_val("t4_do_kept", net_do, 64'h1111_2222_3333_4444);
        cycle(1'b1, 1'b1, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd0, 1'b1);
        #1 chk_val("t4_so_low", {63'd0, net_so}, 64'd0);
        chk_val("t4_do_after", net_do, 64'h1111_2222_3333_4444);
        // Stores to read-only addresses are ignored
        cycle(1'b1, 1'b1, 2'b00, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 64'd0, 1'b0);
        cycle(1'b1, 1'b1, 2'b11, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 64'd0, 1'b0);

        // T5: backpressure on the input channel
        cycle(1'b0, 1'b0, 2'b00, 64'd0, 1'b1, 64'h0000_0000_0000_00A1, 1'b0);
        cycle(1'b0, 1'b0, 2'b00, 64'd0, 1'b1, 64'h0000_0000_0000_00B2, 1'b0);
        cycle(1'b1, 1'b0, 2'b00, 64'd0, 1'b1, 64'h0000_0000_0000_00B2, 1'b0);
        cycle(1'b0, 1'b0, 2'b00, 64'd0, 1'b1, 64'h0000_0000_0000_00B2, 1'b0);
        cycle(1'b1, 1'b0, 2'b00, 64'd0, 1'b0, 64'd0, 1'b0);
        chk_val("t5_new_data", d_out, 64'h0000_0000_0000_00B2);

        // T6: reset with both buffers full
        cycle(1'b1, 1'b1, 2'b10, 64'h5555_0000_5555_0000, 1'b1, 64'h7777_8888_9999_AAAA, 1'b0);
        idle();
        mid_reset();
        cycle(1'b1, 1'b0, 2'b01, 64'd0, 1'b0, 64'd0, 1'b0);
        cycle(1'b1, 1'b0, 2'b00, 64'd0, 1'b0, 64'd0, 1'b0);

        // Randomized traffic on both channels
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 3) != 0), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
                  {$urandom, $urandom}, ($urandom_range(0, 2) != 0), {$urandom, $urandom},
                  ($urandom_range(0, 2) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt_r, miss_cnt_r);
        $finish;
    end

endmodule
